// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : MIPS instruction fetch front end. Holds the fetch PC, runs a
//               single-outstanding req/ack transaction with instruction
//               memory, buffers up to two {pc, word} entries for decode and
//               restarts fetch on branch/jump redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  instr_op
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_nxt;

    // Two-entry buffer kept as a shift structure: entry 0 is always the head,
    // so the head registers naturally hold their last value once emptied.
    logic [1:0]  r_count;
    logic [31:0] r_pc0;
    logic [31:0] r_word0;
    logic [31:0] r_pc1;
    logic [31:0] r_word1;

    logic        w_req;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_target;
    logic        w_unused_bits;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    assign w_target      = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = ^redirect_pc[1:0];

    // Next-state, fetch PC and pending-target logic for the RUN/DRAIN machine.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_req          = 1'b0;
        w_push         = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Only acks fill the buffer, so a raised request always has room.
                w_req = (r_count != 2'd2);
                if (redirect) begin
                    if (w_req && !imem_ack) begin
                        // Request in flight: keep the address stable until its ack.
                        w_state_nxt   = ST_DRAIN;
                        w_pend_pc_nxt = w_target;
                    end else begin
                        w_fetch_pc_nxt = w_target;
                    end
                end else if (w_req && imem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                end
            end
            ST_DRAIN: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    // Drained data is discarded; a coincident redirect wins.
                    w_state_nxt    = ST_RUN;
                    w_fetch_pc_nxt = redirect ? w_target : r_pend_pc;
                end else if (redirect) begin
                    w_pend_pc_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // A redirect takes priority over any pop in the same cycle.
    assign w_pop = (r_count != 2'd0) && instr_ready && !redirect;

    // FSM state, fetch PC and saved redirect target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
        end
    end

    // Instruction buffer: flush on redirect, otherwise push/pop bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_pc0   <= 32'd0;
            r_word0 <= 32'd0;
            r_pc1   <= 32'd0;
            r_word1 <= 32'd0;
        end else if (redirect) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0   <= r_fetch_pc;
                        r_word0 <= imem_rdata;
                    end else begin
                        r_pc1   <= r_fetch_pc;
                        r_word1 <= imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_pc0   <= r_pc1;
                        r_word0 <= r_word1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push needs count < 2 and pop needs count > 0: count is 1.
                    r_pc0   <= r_fetch_pc;
                    r_word0 <= imem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Request drops combinationally with the asynchronous reset.
    assign imem_req    = w_req && !rst;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_word0;
    assign instr_pc    = r_pc0;
    assign instr_op    = r_word0[31:26];

endmodule
`default_nettype wire
